alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 21 ++
 rtl/seq_muldiv.sv | 80 ++++++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADDU  = 4'b0000;
    localparam logic [3:0] OP_SUBU  = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
// Operands are captured on load; each step produces the next {hi,lo} pair,
// which is exposed combinationally so the parent can register the final step.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic [WIDTH-1:0] lo_nxt_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    // acc_q: partial product high half / partial remainder
    // ql_q : multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] ql_q;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;

    // One iteration of the selected algorithm computed from the current state.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q} + (ql_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_q, ql_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        hi_nxt_o    = acc_q;
        lo_nxt_o    = ql_q;
        if (div_q) begin
            // Bit WIDTH of the difference set means the trial subtraction borrowed.
            if (!div_diff_s[WIDTH]) begin
                hi_nxt_o = div_diff_s[WIDTH-1:0];
                lo_nxt_o = {ql_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_o = div_shift_s[WIDTH-1:0];
                lo_nxt_o = {ql_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt_o = mul_sum_s[WIDTH:1];
            lo_nxt_o = {mul_sum_s[0], ql_q[WIDTH-1:1]};
        end
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));

    // Operand capture on load, then one iteration per step with counter advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= {WIDTH{1'b0}};
            ql_q   <= {WIDTH{1'b0}};
            opnd_q <= {WIDTH{1'b0}};
            div_q  <= 1'b0;
            cnt_q  <= {CW{1'b0}};
        end else if (load_i) begin
            acc_q  <= {WIDTH{1'b0}};
            ql_q   <= div_i ? a_i : b_i;
            opnd_q <= div_i ? b_i : a_i;
            div_q  <= div_i;
            cnt_q  <= {CW{1'b0}};
        end else if (step_i) begin
            acc_q  <= hi_nxt_o;
            ql_q   <= lo_nxt_o;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative multu/divu.
// Results are registered and announced by a one-cycle done pulse.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             load_s, div_s, step_s, last_s;
    logic [WIDTH-1:0] hi_nxt_s, lo_nxt_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   slt_diff_s;
    logic             add_ovf_s;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_s),
        .div_i    (div_s),
        .step_i   (step_s),
        .a_i      (a),
        .b_i      (b),
        .hi_nxt_o (hi_nxt_s),
        .lo_nxt_o (lo_nxt_s),
        .last_o   (last_s)
    );

    // Next state, single-cycle results and iterative-op completion.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        load_s     = 1'b0;
        div_s      = 1'b0;
        step_s     = 1'b0;
        sum_s      = a + b;
        // Sign-extended difference cannot wrap, so bit WIDTH is the true sign.
        slt_diff_s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        add_ovf_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    hi_d   = {WIDTH{1'b0}};
                    ovf_d  = 1'b0;
                    case (op)
                        OP_ADDU: lo_d = sum_s;
                        OP_SUBU: lo_d = a - b;
                        OP_OR:   lo_d = a | b;
                        OP_ADD: begin
                            lo_d  = add_ovf_s ? {WIDTH{1'b0}} : sum_s;
                            ovf_d = add_ovf_s;
                        end
                        OP_SLT:  lo_d = {{(WIDTH-1){1'b0}}, slt_diff_s[WIDTH]};
                        OP_LUI:  lo_d = b;
                        OP_AND:  lo_d = a & b;
                        OP_XOR:  lo_d = a ^ b;
                        OP_MULTU: begin
                            done_d  = 1'b0;
                            lo_d    = lo_q;
                            hi_d    = hi_q;
                            ovf_d   = ovf_q;
                            load_s  = 1'b1;
                            state_d = ST_MUL;
                        end
                        OP_DIVU: begin
                            if (b == {WIDTH{1'b0}}) begin
                                // Divide by zero resolves immediately and flags overflow.
                                lo_d  = {WIDTH{1'b1}};
                                hi_d  = a;
                                ovf_d = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                lo_d    = lo_q;
                                hi_d    = hi_q;
                                ovf_d   = ovf_q;
                                load_s  = 1'b1;
                                div_s   = 1'b1;
                                state_d = ST_DIV;
                            end
                        end
                        default: lo_d = {WIDTH{1'b0}};
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                step_s = 1'b1;
                if (last_s) begin
                    lo_d    = lo_nxt_s;
                    hi_d    = hi_nxt_s;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (lo_d == {WIDTH{1'b0}});
    end

    // State and output registers; reset aborts any running op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lo_q    <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign lo       = lo_q;
    assign hi       = hi_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
